axis_monitor_scheduler: RTL and testbench

Time-shares one `fps_counter` stream monitor between `NUM_STREAMS` AXI-Stream taps. The scheduler selects one tap at a time and forwards it to the monitor's `i_axis_in_*` inputs, starting each slot only on a frame boundary. It advances round-robin after `DWELL_FRAMES` complete frames, or after a timeout. It sits beside the video pipeline as a passive observer and never drives the observed streams' `tready`.

---
 rtl/axis_monitor_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_axis_monitor_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_monitor_scheduler.sv
// axis_monitor_scheduler
// Time-shares one fps_counter stream monitor between NUM_STREAMS AXI-Stream
// taps. One tap at a time is gated through to the monitor. A slot always
// starts on a frame boundary. After DWELL_FRAMES complete frames the slot
// advances round-robin over the masked streams. The block only observes the
// streams and never drives tready back into the pipeline.
//
// Optional feature: define SCHED_TIMEOUT_EN to abandon a slot after
// TIMEOUT_CYCLES cycles without a frame start. The timed-out stream is then
// marked not alive.
//
// Ports
//   i_axi_clk, i_axi_rst   clock, asynchronous active-low reset
//   i_enable               scheduler run enable
//   i_stream_mask          per-stream eligibility
//   i_tap_t*               per-stream tap bits (tdata packed, W bits per stream)
//   o_mon_t*               gated tap forwarded to the monitor (registered)
//   o_sel                  index of the selected stream
//   o_monitoring           high while a slot is open (MONITOR)
//   o_switch_stb           one-cycle pulse when the slot advances
//   o_stream_alive         per-stream frame-activity status
module axis_monitor_scheduler #(
  parameter int unsigned NUM_STREAMS     = 4,
  parameter int unsigned AXIS_DATA_WIDTH = 8,
  parameter int unsigned DWELL_FRAMES    = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 100000000,
  parameter int unsigned SEL_WIDTH       = $clog2(NUM_STREAMS)
) (
  input  logic                                   i_axi_clk,
  input  logic                                   i_axi_rst,
  input  logic                                   i_enable,
  input  logic [NUM_STREAMS-1:0]                 i_stream_mask,
  input  logic [NUM_STREAMS-1:0]                 i_tap_tuser,
  input  logic [NUM_STREAMS-1:0]                 i_tap_tvalid,
  input  logic [NUM_STREAMS-1:0]                 i_tap_tready,
  input  logic [NUM_STREAMS-1:0]                 i_tap_tlast,
  input  logic [NUM_STREAMS*AXIS_DATA_WIDTH-1:0] i_tap_tdata,
  output logic                                   o_mon_tuser,
  output logic                                   o_mon_tvalid,
  output logic                                   o_mon_tready,
  output logic                                   o_mon_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]             o_mon_tdata,
  output logic [SEL_WIDTH-1:0]                   o_sel,
  output logic                                   o_monitoring,
  output logic                                   o_switch_stb,
  output logic [NUM_STREAMS-1:0]                 o_stream_alive
);

  localparam int unsigned CNT_W = $clog2(DWELL_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MONITOR = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [SEL_WIDTH-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_STREAMS-1:0]     alive_q, alive_d;
  logic                       stb_q, stb_d;
  logic                       monitoring_q, monitoring_d;
  logic [NUM_STREAMS-1:0]     tuser_prev_q;
  logic                       mon_tuser_q, mon_tvalid_q, mon_tready_q, mon_tlast_q;
  logic                       mon_tuser_d, mon_tvalid_d, mon_tready_d, mon_tlast_d;
  logic [AXIS_DATA_WIDTH-1:0] mon_tdata_q, mon_tdata_d;

  logic [NUM_STREAMS-1:0]     frame_start;
  logic                       sel_fs;
  logic [SEL_WIDTH-1:0]       low_idx;
  logic [SEL_WIDTH-1:0]       nxt_idx;
  logic [AXIS_DATA_WIDTH-1:0] tap_tdata;
  logic [CNT_W-1:0]           cnt_inc;
  logic                       fwd;
  logic                       advance;
  logic                       tmo_hit;

  // Rising edge of tuser, tracked on every stream regardless of selection
  assign frame_start = i_tap_tuser & ~tuser_prev_q;
  assign sel_fs      = frame_start[sel_q];

  // Selected tdata lane
  always_comb begin
    tap_tdata = '0;
    for (int k = 0; k < int'(NUM_STREAMS); k++) begin
      if (SEL_WIDTH'(k) == sel_q) tap_tdata = i_tap_tdata[k*int'(AXIS_DATA_WIDTH) +: AXIS_DATA_WIDTH];
    end
  end

  // Lowest masked stream (slot start from IDLE) and next masked above sel_q
  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_STREAMS) - 1; i >= 0; i--) begin
      if (i_stream_mask[i]) low_idx = SEL_WIDTH'(i);
    end
    nxt_idx = sel_q;
    for (int i = int'(NUM_STREAMS) - 1; i >= 1; i--) begin
      if (i_stream_mask[(int'(sel_q) + i) % int'(NUM_STREAMS)]) begin
        nxt_idx = SEL_WIDTH'((int'(sel_q) + i) % int'(NUM_STREAMS));
      end
    end
  end

  // Completed-frame count after this frame start, saturating at DWELL_FRAMES
  assign cnt_inc = (cnt_q == CNT_W'(DWELL_FRAMES)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state, gate decision and registered-output inputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    alive_d = alive_q;
    stb_d   = 1'b0;
    fwd     = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && (|i_stream_mask)) begin
          state_d = ST_SYNC;
          sel_d   = low_idx;
        end
      end
      ST_SYNC, ST_MONITOR: begin
        // Priority: disable > mask clear > timeout > frame start
        if (!i_enable || !(|i_stream_mask)) begin
          state_d = ST_IDLE;
        end else if (!i_stream_mask[sel_q]) begin
          advance = 1'b1;
        end else if (tmo_hit) begin
          alive_d[sel_q] = 1'b0;
          advance        = 1'b1;
        end else if (sel_fs) begin
          if (state_q == ST_SYNC) begin
            fwd            = 1'b1;
            cnt_d          = '0;
            alive_d[sel_q] = 1'b1;
            state_d        = ST_MONITOR;
          end else begin
            cnt_d = cnt_inc;
            // The start of the frame after the last dwelled one is dropped
            if (cnt_inc == CNT_W'(DWELL_FRAMES)) advance = 1'b1;
            else                                 fwd     = 1'b1;
          end
        end else if (state_q == ST_MONITOR) begin
          fwd = 1'b1;
        end
        if (advance) begin
          sel_d   = nxt_idx;
          stb_d   = 1'b1;
          state_d = ST_SYNC;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    monitoring_d = (state_d == ST_MONITOR);
    mon_tuser_d  = fwd & i_tap_tuser[sel_q];
    mon_tvalid_d = fwd & i_tap_tvalid[sel_q];
    mon_tready_d = fwd & i_tap_tready[sel_q];
    mon_tlast_d  = fwd & i_tap_tlast[sel_q];
    mon_tdata_d  = fwd ? tap_tdata : '0;
  end

`ifdef SCHED_TIMEOUT_EN
  // Cycles since slot entry or last frame start of the selected stream
  always_comb begin
    tmo_d = tmo_q + TMO_W'(1);
    if (state_d == ST_IDLE || state_d != state_q || advance || sel_fs) tmo_d = '0;
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end
`endif

  // All state and registered outputs
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      alive_q      <= '0;
      stb_q        <= 1'b0;
      monitoring_q <= 1'b0;
      tuser_prev_q <= '0;
      mon_tuser_q  <= 1'b0;
      mon_tvalid_q <= 1'b0;
      mon_tready_q <= 1'b0;
      mon_tlast_q  <= 1'b0;
      mon_tdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      alive_q      <= alive_d;
      stb_q        <= stb_d;
      monitoring_q <= monitoring_d;
      tuser_prev_q <= i_tap_tuser;
      mon_tuser_q  <= mon_tuser_d;
      mon_tvalid_q <= mon_tvalid_d;
      mon_tready_q <= mon_tready_d;
      mon_tlast_q  <= mon_tlast_d;
      mon_tdata_q  <= mon_tdata_d;
    end
  end

  assign o_mon_tuser    = mon_tuser_q;
  assign o_mon_tvalid   = mon_tvalid_q;
  assign o_mon_tready   = mon_tready_q;
  assign o_mon_tlast    = mon_tlast_q;
  assign o_mon_tdata    = mon_tdata_q;
  assign o_sel          = sel_q;
  assign o_monitoring   = monitoring_q;
  assign o_switch_stb   = stb_q;
  assign o_stream_alive = alive_q;

endmodule

// File: tb/tb_axis_monitor_scheduler.sv
// Directed bench for axis_monitor_scheduler: NUM_STREAMS=4, DWELL_FRAMES=2,
// TIMEOUT_CYCLES=1000. Every stream sends 8x4-beat frames with a per-stream
// phase offset; tdata[7:6] carries the stream index, tdata[5:0] the beat.
module tb_axis_monitor_scheduler;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned DWELL = 2;
  localparam int unsigned TMO  = 1000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   mask;
  logic [N-1:0]   tuser, tvalid, tready, tlast;
  logic [N*W-1:0] tdata;
  logic           mon_tuser, mon_tvalid, mon_tready, mon_tlast;
  logic [W-1:0]   mon_tdata;
  logic [1:0]     sel;
  logic           monitoring, switch_stb;
  logic [N-1:0]   alive;

  logic [N-1:0]   silent;
  logic [N*W-1:0] prev_tdata;
  int             cyc;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  axis_monitor_scheduler #(
    .NUM_STREAMS(N), .AXIS_DATA_WIDTH(W), .DWELL_FRAMES(DWELL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_axi_clk(clk), .i_axi_rst(rst_n), .i_enable(enable), .i_stream_mask(mask),
    .i_tap_tuser(tuser), .i_tap_tvalid(tvalid), .i_tap_tready(tready),
    .i_tap_tlast(tlast), .i_tap_tdata(tdata),
    .o_mon_tuser(mon_tuser), .o_mon_tvalid(mon_tvalid), .o_mon_tready(mon_tready),
    .o_mon_tlast(mon_tlast), .o_mon_tdata(mon_tdata), .o_sel(sel),
    .o_monitoring(monitoring), .o_switch_stb(switch_stb), .o_stream_alive(alive)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beat_of(input int k, input int c);
    return (c + 5 * k) % 32;
  endfunction

  task automatic drive();
    int b;
    prev_tdata = tdata;
    for (int k = 0; k < int'(N); k++) begin
      b = beat_of(k, cyc);
      if (silent[k]) begin
        tuser[k] = 1'b0; tvalid[k] = 1'b0; tready[k] = 1'b0; tlast[k] = 1'b0;
        tdata[k*int'(W) +: W] = '0;
      end else begin
        tuser[k]  = (b == 0);
        tvalid[k] = 1'b1;
        tready[k] = ((b % 4) != 3);
        tlast[k]  = ((b % 8) == 7);
        tdata[k*int'(W) +: W] = W'((k << 6) | b);
      end
    end
  endtask

  // One clock; outputs sampled afterwards reflect the taps driven before it
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fs_cnt, nsw, bad, early;
    int exp_rr[4];
    int exp_alt[3];
    exp_rr  = '{1, 2, 3, 0};
    exp_alt = '{2, 0, 2};

    rst_n = 1'b0; enable = 1'b0; mask = '0; silent = '0; cyc = 0;
    tuser = '0; tvalid = '0; tready = '0; tlast = '0; tdata = '0;
    drive();

    // Reset state
    repeat (3) tick();
    chk("rst_mon", {mon_tuser, mon_tvalid, mon_tready, mon_tlast, mon_tdata}, 32'h0);
    chk("rst_sel", sel, 0);
    chk("rst_flags", {monitoring, switch_stb}, 0);
    chk("rst_alive", alive, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_mon", {monitoring, mon_tvalid}, 0);

    // Enable mid-frame on stream 0: first forwarded beat is the next frame start
    while (beat_of(0, cyc) != 10) tick();
    mask = 4'b1111; enable = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mon_tvalid && n < 64);
    chk("first_fwd_latency", n, 23);
    chk("first_fwd_tuser", mon_tuser, 1);
    chk("first_fwd_tdata", mon_tdata, 8'h00);
    chk("first_fwd_sel", sel, 0);
    chk("first_fwd_monitoring", monitoring, 1);

    // Round robin over all four streams, two frames per slot
    fs_cnt = 1; nsw = 0; bad = 0; n = 0;
    while (nsw < 4 && n < 1000) begin
      tick(); n++;
      if (switch_stb) begin
        chk("rr_frames_per_slot", fs_cnt, 2);
        chk("rr_sel", sel, exp_rr[nsw]);
        chk("rr_gap", {mon_tuser, mon_tvalid, mon_tready, mon_tlast, mon_tdata}, 32'h0);
        nsw++; fs_cnt = 0;
      end else if (mon_tvalid) begin
        if (mon_tuser) fs_cnt++;
        if (mon_tdata !== prev_tdata[int'(sel)*int'(W) +: W]) bad++;
      end
    end
    chk("rr_switches", nsw, 4);
    chk("rr_data", bad, 0);
    chk("rr_alive", alive, 4'b1111);

    // Mask 0101: alternate 0 and 2, streams 1 and 3 never forwarded
    enable = 1'b0;
    tick();
    chk("dis_sel_held0", sel, 0);
    mask = 4'b0101; enable = 1'b1;
    tick();
    nsw = 0; bad = 0; n = 0;
    while (nsw < 3 && n < 1000) begin
      tick(); n++;
      if (sel[0]) bad++;
      if (mon_tvalid && mon_tdata[6]) bad++;
      if (switch_stb) begin
        chk("alt_sel", sel, exp_alt[nsw]);
        nsw++;
      end
    end
    chk("alt_switches", nsw, 3);
    chk("alt_excluded", bad, 0);

    // Disable: IDLE at the next edge with o_sel held at 2
    enable = 1'b0;
    tick();
    chk("dis_sel_held", sel, 2);
    chk("dis_mon", {monitoring, mon_tvalid}, 0);
    tick();
    chk("dis_no_stb", switch_stb, 0);
    enable = 1'b1;
    tick();
    chk("reen_sel_lowest", sel, 0);

    // Mask clear of stream 0 in the same cycle as its frame start
    n = 0;
    while (tuser[0] !== 1'b1 && n < 64) begin tick(); n++; end
    chk("mclr_found_fs", tuser[0], 1);
    mask = 4'b0100;
    tick();
    chk("mclr_stb", switch_stb, 1);
    chk("mclr_sel", sel, 2);
    chk("mclr_dropped", {mon_tuser, mon_tvalid}, 0);

`ifdef SCHED_TIMEOUT_EN
    // Silent stream 1 is abandoned after TIMEOUT_CYCLES
    mask = 4'b1111; silent = 4'b0010;
    n = 0;
    do begin tick(); n++; end while (!(switch_stb && sel == 2'd1) && n < 1000);
    chk("tmo_enter_sel1", {switch_stb, sel}, {1'b1, 2'd1});
    chk("tmo_alive_before", alive[1], 1);
    early = 0;
    repeat (int'(TMO) - 1) begin
      tick();
      if (switch_stb) early++;
    end
    chk("tmo_no_early_stb", early, 0);
    tick();
    chk("tmo_stb", switch_stb, 1);
    chk("tmo_sel", sel, 2);
    chk("tmo_alive_cleared", alive[1], 0);
`endif

    // Asynchronous reset mid-MONITOR on stream 2
    n = 0;
    do begin tick(); n++; end while (!(monitoring && sel == 2'd2) && n < 200);
    chk("pre_rst_monitor_s2", {monitoring, sel}, {1'b1, 2'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mon", {mon_tuser, mon_tvalid, mon_tready, mon_tlast, mon_tdata}, 32'h0);
    chk("arst_sel", sel, 0);
    chk("arst_flags", {monitoring, switch_stb}, 0);
    chk("arst_alive", alive, 0);
    rst_n = 1'b1; mask = 4'b1111; silent = '0;
    tick();
    chk("post_rst_sync", {sel, monitoring, mon_tvalid}, 0);
    n = 0;
    do begin tick(); n++; end while (!mon_tvalid && n < 64);
    chk("post_rst_first_tuser", mon_tuser, 1);
    chk("post_rst_first_sel", sel, 0);
    chk("post_rst_first_tdata", mon_tdata, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
